imm_decode_stage: RTL and testbench

Decode-side pipeline stage that classifies each fetched RV32I instruction, produces the immediate-extender configuration (`imm_src`, `signed`), and registers it together with `instr[31:7]` and the PC for the execute stage. The stage uses a two-entry skid buffer with valid/ready handshakes on both sides. Flush and back-pressure are handled without losing or duplicating beats. It sits between fetch and the sign-extension/execute logic, and its outputs drive the extender's select inputs directly.

---
 rtl/imm_decode_stage.sv | 199 +++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_decode_stage
//  Purpose  : RV32I decode-side pipeline stage. Classifies each fetched
//             instruction, produces the immediate-extender configuration
//             (imm_src, signed) and registers it with instr[31:7] and the PC.
//             A two-entry skid buffer sits behind valid/ready handshakes on
//             both sides.
//  Ports    : clk_i, rst_i (sync, active-high)
//             in_valid_i / in_ready_o / instr_i / pc_i   - fetch side
//             flush_i                                    - drop all beats
//             out_valid_o / out_ready_i                  - execute side
//             instr_31_7_o, pc_o, imm_src_o, signed_o,
//             uses_imm_o, illegal_o                      - output payload
//             illegal_cnt_o                              - saturating count
//  Revision : 1.0 - initial release
// ============================================================================
module imm_decode_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [24:0] instr_31_7_o,
  output logic [31:0] pc_o,
  output logic [2:0]  imm_src_o,
  output logic        signed_o,
  output logic        uses_imm_o,
  output logic        illegal_o,
  output logic [7:0]  illegal_cnt_o
);

  // Payload layout: {instr[31:7], pc, imm_src, signed, uses_imm, illegal}
  localparam int c_PAYLOAD_W = 25 + 32 + 3 + 1 + 1 + 1;

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [1:0]             r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [c_PAYLOAD_W-1:0] r_out;
  logic [c_PAYLOAD_W-1:0] r_skid;
  logic [7:0]             r_illegal_cnt;

  logic [2:0]             w_imm_src;
  logic                   w_signed;
  logic                   w_uses_imm;
  logic                   w_illegal;
  logic [c_PAYLOAD_W-1:0] w_in_payload;

  logic                   w_accept;
  logic                   w_fire;
  logic [1:0]             w_state_next;
  logic                   w_load_out_in;
  logic                   w_load_out_skid;
  logic                   w_load_skid;

  // --------------------------------------------------------------------------
  // Instruction classification
  // --------------------------------------------------------------------------
  always_comb begin
    w_imm_src  = 3'b000;
    w_signed   = 1'b0;
    w_uses_imm = 1'b0;
    w_illegal  = 1'b0;
    case (instr_i[6:0])
      7'b0000011, 7'b1100111: begin  // load, JALR
        w_signed   = 1'b1;
        w_uses_imm = 1'b1;
      end
      7'b0010011: begin              // OP-IMM
        w_uses_imm = 1'b1;
        if (instr_i[14:12] == 3'b001 || instr_i[14:12] == 3'b101) begin
          // Shift-immediate: instr[30] separates SRAI from SRLI/SLLI
          w_imm_src = 3'b101;
          w_signed  = instr_i[30];
        end else begin
          w_signed  = 1'b1;
        end
      end
      7'b0100011: begin              // store
        w_imm_src  = 3'b001;
        w_signed   = 1'b1;
        w_uses_imm = 1'b1;
      end
      7'b1100011: begin              // branch
        w_imm_src  = 3'b010;
        w_signed   = 1'b1;
        w_uses_imm = 1'b1;
      end
      7'b0110111, 7'b0010111: begin  // LUI, AUIPC
        w_imm_src  = 3'b011;
        w_signed   = 1'b1;
        w_uses_imm = 1'b1;
      end
      7'b1101111: begin              // JAL
        w_imm_src  = 3'b100;
        w_signed   = 1'b1;
        w_uses_imm = 1'b1;
      end
      7'b0110011, 7'b0001111, 7'b1110011: begin
        // OP, FENCE, SYSTEM: legal, no immediate
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_in_payload = {instr_i[31:7], pc_i, w_imm_src, w_signed,
                         w_uses_imm, w_illegal};

  // --------------------------------------------------------------------------
  // Skid-buffer control
  // --------------------------------------------------------------------------
  assign w_accept = in_valid_i & r_in_ready;
  assign w_fire   = r_out_valid & out_ready_i;

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush_i) begin
      w_state_next = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_accept) begin
            w_state_next  = c_ONE;
            w_load_out_in = 1'b1;
          end
        end
        c_ONE: begin
          if (w_accept && w_fire) begin
            w_load_out_in = 1'b1;
          end else if (w_accept) begin
            w_state_next = c_FULL;
            w_load_skid  = 1'b1;
          end else if (w_fire) begin
            w_state_next = c_EMPTY;
          end
        end
        c_FULL: begin
          if (w_fire) begin
            w_state_next    = c_ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: w_state_next = c_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= c_EMPTY;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out         <= '0;
      r_skid        <= '0;
      r_illegal_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      // Ready and valid come from the next state so neither depends
      // combinationally on out_ready_i.
      r_in_ready  <= (w_state_next != c_FULL);
      r_out_valid <= (w_state_next != c_EMPTY);
      if (w_load_out_in) begin
        r_out <= w_in_payload;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_payload;
      end
      // A fire in a flush cycle is discarded and therefore not counted
      if (w_fire && !flush_i && r_out[0] && (r_illegal_cnt != 8'hFF)) begin
        r_illegal_cnt <= r_illegal_cnt + 8'd1;
      end
    end
  end

  assign in_ready_o    = r_in_ready;
  assign out_valid_o   = r_out_valid;
  assign instr_31_7_o  = r_out[c_PAYLOAD_W-1 -: 25];
  assign pc_o          = r_out[37:6];
  assign imm_src_o     = r_out[5:3];
  assign signed_o      = r_out[2];
  assign uses_imm_o    = r_out[1];
  assign illegal_o     = r_out[0];
  assign illegal_cnt_o = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_decode_stage
//  Purpose  : Self-checking bench for imm_decode_stage. Keeps a queue of
//             accepted beats as the reference and decodes expected fields
//             straight from the RV32I opcode rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] instr_31_7;
  logic [31:0] pc_out;
  logic [2:0]  imm_src;
  logic        sgn;
  logic        uses_imm;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  imm_decode_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .instr_i       (instr),
    .pc_i          (pc),
    .flush_i       (flush),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .instr_31_7_o  (instr_31_7),
    .pc_o          (pc_out),
    .imm_src_o     (imm_src),
    .signed_o      (sgn),
    .uses_imm_o    (uses_imm),
    .illegal_o     (illegal),
    .illegal_cnt_o (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  typedef struct {
    logic [2:0] imm_src;
    logic       sgn;
    logic       uses;
    logic       ill;
  } dec_t;

  beat_t m_q[$];
  int    m_cnt;
  int    n_pass;
  int    n_total;

  // Expected extender configuration, written from the opcode table.
  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    d.imm_src = 3'd0; d.sgn = 1'b0; d.uses = 1'b0; d.ill = 1'b0;
    if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      d.imm_src = 3'd5; d.sgn = ins[30]; d.uses = 1'b1;
    end else if (op == 7'h03 || op == 7'h67 || op == 7'h13) begin
      d.sgn = 1'b1; d.uses = 1'b1;
    end else if (op == 7'h23) begin
      d.imm_src = 3'd1; d.sgn = 1'b1; d.uses = 1'b1;
    end else if (op == 7'h63) begin
      d.imm_src = 3'd2; d.sgn = 1'b1; d.uses = 1'b1;
    end else if (op == 7'h37 || op == 7'h17) begin
      d.imm_src = 3'd3; d.sgn = 1'b1; d.uses = 1'b1;
    end else if (op == 7'h6F) begin
      d.imm_src = 3'd4; d.sgn = 1'b1; d.uses = 1'b1;
    end else if (op != 7'h33 && op != 7'h0F && op != 7'h73) begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    dec_t d;
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
    if (m_q.size() > 0) begin
      d = ref_dec(m_q[0].instr);
      chk("instr_31_7", 64'(instr_31_7), 64'(m_q[0].instr[31:7]));
      chk("pc", 64'(pc_out), 64'(m_q[0].pc));
      chk("imm_src", 64'(imm_src), 64'(d.imm_src));
      chk("signed", 64'(sgn), 64'(d.sgn));
      chk("uses_imm", 64'(uses_imm), 64'(d.uses));
      chk("illegal", 64'(illegal), 64'(d.ill));
    end
  endtask

  // One clock cycle: drive inputs, advance the queue model, check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic fl, input logic rdy);
    logic  acc;
    logic  fir;
    beat_t b;
    in_valid  = v;
    instr     = ins;
    pc        = p;
    flush     = fl;
    out_ready = rdy;
    acc = v && (m_q.size() < 2);
    fir = rdy && (m_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      m_q.delete();
    end else begin
      if (fir) begin
        b = m_q.pop_front();
        if (ref_dec(b.instr).ill && m_cnt < 255) m_cnt++;
      end
      if (acc) begin
        b.instr = ins;
        b.pc    = p;
        m_q.push_back(b);
      end
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [13];
    logic [31:0] w;
    ops = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 15) != 0) w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  initial begin
    int saved;
    n_pass = 0; n_total = 0; m_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt", 64'(illegal_cnt), 64'd0);
    chk("rst_payload", {instr_31_7, pc_out, imm_src, sgn, uses_imm, illegal}, 64'd0);
    rst = 1'b0;

    // ADDI x1, x0, -1
    step(1'b1, 32'hFFF00093, 32'h0000_1000, 1'b0, 1'b1);
    chk("addi_instr_31_7", 64'(instr_31_7), 64'h1FFE001);
    chk("addi_imm_src", 64'(imm_src), 64'd0);
    chk("addi_signed", 64'(sgn), 64'd1);
    // SRAI, SRLI, branch, JAL back-to-back
    step(1'b1, 32'h4030D093, 32'h0000_1004, 1'b0, 1'b1);
    chk("srai_imm_src", 64'(imm_src), 64'd5);
    chk("srai_signed", 64'(sgn), 64'd1);
    step(1'b1, 32'h0030D093, 32'h0000_1008, 1'b0, 1'b1);
    chk("srli_imm_src", 64'(imm_src), 64'd5);
    chk("srli_signed", 64'(sgn), 64'd0);
    step(1'b1, 32'h00208463, 32'h0000_100C, 1'b0, 1'b1);
    chk("branch_imm_src", 64'(imm_src), 64'd2);
    step(1'b1, 32'h0080006F, 32'h0000_1010, 1'b0, 1'b1);
    chk("jal_imm_src", 64'(imm_src), 64'd4);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Back-pressure: A, B accepted, C stalls until space frees up
    step(1'b1, 32'h00000013, 32'h0000_2000, 1'b0, 1'b0);
    step(1'b1, 32'h00002023, 32'h0000_2004, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 32'h000000B7, 32'h0000_2008, 1'b0, 1'b0);
    step(1'b1, 32'h000000B7, 32'h0000_2008, 1'b0, 1'b1);
    step(1'b1, 32'h000000B7, 32'h0000_2008, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush while FULL with a new beat offered in the same cycle
    step(1'b1, 32'h00000003, 32'h0000_3000, 1'b0, 1'b0);
    step(1'b1, 32'h00000067, 32'h0000_3004, 1'b0, 1'b0);
    step(1'b1, 32'h00000017, 32'h0000_3008, 1'b1, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h00000033, 32'h0000_300C, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // A fire during a flush cycle must not be counted
    saved = m_cnt;
    step(1'b1, 32'h0000007F, 32'h0000_4000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("flush_fire_cnt", 64'(illegal_cnt), 64'(saved));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Illegal opcode 257 times: counter saturates at 255
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 32'h0000007F, 32'(i), 1'b0, 1'b1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("illegal_cnt_sat", 64'(illegal_cnt), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
